// File: rtl/trig_pkg.sv
// Shared state encoding and default parameters for the trigger conditioner.
package trig_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL_HI = 3'd1,
    ACTIVE  = 3'd2,
    QUAL_LO = 3'd3,
    HOLDOFF = 3'd4
  } trig_state_t;

  localparam int TRIG_SYNC_STAGES    = 2;
  localparam int TRIG_FILTER_CYCLES  = 4;
  localparam int TRIG_HOLDOFF_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trig_sync.sv
// N-flop synchronizer, async active-low reset to 0; latency STAGES edges, no backpressure.
module trig_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// Sync + glitch filter + hold-off for an external trigger; SYNC_STAGES+FILTER_CYCLES edges each way.
// Optional glitch counter compiled in with TRIG_GLITCH_CNT_EN; no backpressure.
module trigger_conditioner
  import trig_pkg::*;
#(
  parameter int SYNC_STAGES    = TRIG_SYNC_STAGES,
  parameter int FILTER_CYCLES  = TRIG_FILTER_CYCLES,
  parameter int HOLDOFF_CYCLES = TRIG_HOLDOFF_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic             trig_in,
  output logic             trig_out,
  output logic             trig_rise,
  output logic             holdoff,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int CW = $clog2(max_int(FILTER_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [CW-1:0] FILT_LOAD = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF_CYCLES);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic        trig_s;
  trig_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        trig_out_q, trig_out_d;
  logic        trig_rise_q, trig_rise_d;
  logic        holdoff_q, holdoff_d;

  trig_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (fastclk),
    .rst_ni (reset),
    .d_i    (trig_in),
    .q_o    (trig_s)
  );

  // cnt holds the samples still needed to qualify, or the hold-off cycles left
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (trig_s) begin
          if (FILTER_CYCLES == 1) begin
            state_d = ACTIVE;
          end else begin
            state_d = QUAL_HI;
            cnt_d   = FILT_LOAD;
          end
        end
      end
      QUAL_HI: begin
        if (!trig_s)           state_d = IDLE;
        else if (cnt_q == ONE) state_d = ACTIVE;
        else                   cnt_d   = cnt_q - ONE;
      end
      ACTIVE: begin
        if (!trig_s) begin
          if (FILTER_CYCLES == 1) begin
            state_d = HOLDOFF;
            cnt_d   = HOLD_LOAD;
          end else begin
            state_d = QUAL_LO;
            cnt_d   = FILT_LOAD;
          end
        end
      end
      QUAL_LO: begin
        if (trig_s) begin
          state_d = ACTIVE;
        end else if (cnt_q == ONE) begin
          state_d = HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      HOLDOFF: begin
        cnt_d = cnt_q - ONE;
        if (cnt_q <= ONE) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign trig_out_d  = (state_d == ACTIVE) || (state_d == QUAL_LO);
  assign trig_rise_d = trig_out_d && !trig_out_q;
  assign holdoff_d   = (state_d == HOLDOFF);

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      trig_out_q  <= 1'b0;
      trig_rise_q <= 1'b0;
      holdoff_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      trig_out_q  <= trig_out_d;
      trig_rise_q <= trig_rise_d;
      holdoff_q   <= holdoff_d;
    end
  end

  assign trig_out  = trig_out_q;
  assign trig_rise = trig_rise_q;
  assign holdoff   = holdoff_q;

`ifdef TRIG_GLITCH_CNT_EN
  logic             glitch_ev;
  logic [CNT_W-1:0] glitch_q, glitch_d;

  // a high that fails qualification is a glitch; saturate rather than wrap
  assign glitch_ev = (state_q == QUAL_HI) && !trig_s;
  assign glitch_d  = (glitch_ev && (glitch_q != {CNT_W{1'b1}})) ? glitch_q + CNT_W'(1) : glitch_q;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) glitch_q <= '0;
    else        glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_trigger_conditioner.sv
// Randomized and directed bench for trigger_conditioner against a run-length reference model.
module tb_trigger_conditioner;

  localparam int SYNC = 2;
  localparam int FILT = 4;
  localparam int HOLD = 16;
  localparam int CNTW = 8;
`ifdef TRIG_GLITCH_CNT_EN
  localparam int EXP_G1  = 1;
  localparam int EXP_SAT = 255;
`else
  localparam int EXP_G1  = 0;
  localparam int EXP_SAT = 0;
`endif

  logic            fastclk = 1'b0;
  logic            reset   = 1'b0;
  logic            trig_in = 1'b1;
  logic            trig_out, trig_rise, holdoff;
  logic [CNTW-1:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  always #2 fastclk = ~fastclk;

  trigger_conditioner #(
    .SYNC_STAGES   (SYNC),
    .FILTER_CYCLES (FILT),
    .HOLDOFF_CYCLES(HOLD),
    .CNT_W         (CNTW)
  ) dut (
    .fastclk   (fastclk),
    .reset     (reset),
    .trig_in   (trig_in),
    .trig_out  (trig_out),
    .trig_rise (trig_rise),
    .holdoff   (holdoff),
    .glitch_cnt(glitch_cnt)
  );

  // Reference: delay line for the synchronizer, then a level that flips only
  // after FILT consecutive opposing samples, followed by HOLD ignored edges.
  int m_sync [SYNC];
  int m_out = 0, m_rise = 0, m_hold = 0, m_run = 0, m_glitch = 0;

  always @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 0;
      m_out = 0; m_rise = 0; m_hold = 0; m_run = 0; m_glitch = 0;
    end else begin
      int s;
      s = m_sync[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = int'(trig_in);
      m_rise = 0;
      if (m_hold > 0) begin
        m_hold--;
      end else if (s != m_out) begin
        m_run++;
        if (m_run == FILT) begin
          m_out  = s;
          m_run  = 0;
          m_rise = s;
          if (s == 0) m_hold = HOLD;
        end
      end else begin
`ifdef TRIG_GLITCH_CNT_EN
        if (m_out == 0 && m_run > 0 && m_glitch < (1 << CNTW) - 1) m_glitch++;
`endif
        m_run = 0;
      end
    end
  end

  always @(negedge fastclk) begin
    int eh;
    eh = (m_hold > 0) ? 1 : 0;
    checks++;
    if (int'(trig_out) != m_out || int'(trig_rise) != m_rise || int'(holdoff) != eh ||
        int'(glitch_cnt) != m_glitch) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: dut out/rise/hold/glitch=%0d/%0d/%0d/%0d model=%0d/%0d/%0d/%0d",
               $time, trig_out, trig_rise, holdoff, glitch_cnt, m_out, m_rise, eh, m_glitch);
    end
  end

  int rise_cnt = 0, out_hi = 0, hold_hi = 0, fall_cnt = 0;
  logic prev_out = 1'b0;

  always @(negedge fastclk) begin
    if (trig_rise) rise_cnt++;
    if (trig_out) out_hi++;
    if (holdoff) hold_hi++;
    if (prev_out && !trig_out) fall_cnt++;
    prev_out = trig_out;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge fastclk);
    #1;
  endtask

  task automatic clr();
    rise_cnt = 0; out_hi = 0; hold_hi = 0; fall_cnt = 0;
  endtask

  initial begin
    #1;
    chk("reset_outputs", int'({trig_out, trig_rise, holdoff}) + int'(glitch_cnt), 0);
    #2;
    reset = 1'b1;
    tick(5);
    chk("rise_latency_5", int'(trig_out), 0);
    tick(1);
    chk("rise_latency_6", int'(trig_out), 1);
    chk("rise_strobe", int'(trig_rise), 1);
    trig_in = 1'b0;
    tick(40);

    clr();
    trig_in = 1'b1; tick(12); trig_in = 1'b0; tick(40);
    chk("clean_rise_count", rise_cnt, 1);
    chk("clean_high_cycles", out_hi, 12);
    chk("clean_holdoff_cycles", hold_hi, 16);

    clr();
    trig_in = 1'b1; tick(2); trig_in = 1'b0; tick(10);
    chk("glitch_no_output", out_hi, 0);
    chk("glitch_count_1", int'(glitch_cnt), EXP_G1);

    clr();
    trig_in = 1'b1; tick(10); trig_in = 1'b0; tick(2); trig_in = 1'b1; tick(10);
    chk("dropout_no_fall", fall_cnt, 0);
    chk("dropout_still_high", int'(trig_out), 1);
    trig_in = 1'b0; tick(5); trig_in = 1'b1; tick(1);
    chk("dropout5_ends", int'(trig_out), 0);
    chk("dropout5_holdoff", int'(holdoff), 1);
    trig_in = 1'b0; tick(40);
    chk("dropout_single_rise", rise_cnt, 1);

    trig_in = 1'b1; tick(12); trig_in = 1'b0;
    tick(5);
    chk("fall_latency_5", int'(trig_out), 1);
    tick(1);
    chk("fall_latency_6", int'(trig_out), 0);
    clr();
    tick(4); trig_in = 1'b1; tick(12); trig_in = 1'b0; tick(40);
    chk("holdoff_retrig_blocked", rise_cnt, 0);

    trig_in = 1'b1; tick(12); trig_in = 1'b0; tick(6);
    clr();
    tick(20); trig_in = 1'b1; tick(12); trig_in = 1'b0; tick(40);
    chk("holdoff_retrig_late", rise_cnt, 1);

    repeat (300) begin
      trig_in = 1'b1; tick(2); trig_in = 1'b0; tick(3);
    end
    tick(5);
    chk("glitch_saturate", int'(glitch_cnt), EXP_SAT);

    trig_in = 1'b1; tick(10);
    chk("pre_reset_active", int'(trig_out), 1);
    reset = 1'b0;
    #1;
    chk("reset_immediate", int'(trig_out), 0);
    chk("reset_no_holdoff", int'(holdoff), 0);
    tick(1);
    reset = 1'b1;
    tick(5);
    chk("post_reset_5", int'(trig_out), 0);
    tick(1);
    chk("post_reset_6", int'(trig_out), 1);

    repeat (300) begin
      trig_in = ~trig_in;
      if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(1, 5)));
      else                           tick(int'($urandom_range(1, 30)));
    end
    trig_in = 1'b0;
    tick(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
